debug_bus_regbank: RTL
======================

# debug_bus_regbank

Responder on `debug_bus_if` that answers read and write transactions from the UART-driven debug bus master. It holds a window of 8-bit configuration registers that the video pipeline reads as static settings, with configurable wait states. It pulses a strobe on every committed write. Several instances share one bus: each occupies an aligned address window and stays silent outside it, so read data can be OR-combined at the interconnect.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000, first address of the window; must be a multiple of `NUM_REGS`
- `NUM_REGS`, 16, number of registers; a power of two, 2..256
- `WAIT_CYCLES`, 2, extra cycles inserted before responding; 0..15
- `RESET_VALUE`, 8'h00, value loaded into every register on reset

Ports:
- `clk`  in  1  single clock for the whole block
- `rst_n`  in  1  asynchronous, active-low reset
- `dbus`  slave modport  —  `debug_bus_if`. Inputs are `addr[15:0]`, `write_data[7:0]`, `write_enable` and `read_enable`. Outputs are `ready`, `read_data[7:0]` and `read_data_valid`.
- `o_regs`  out  `NUM_REGS*8`  register contents; register i is at bits [8i+7:8i]
- `o_write_strobe`  out  1  one-cycle pulse when a write commits
- `o_write_index`  out  `$clog2(NUM_REGS)`  index of the last committed write

## Operation
- The master holds `write_enable` with `addr` and `write_data` stable until it sees `ready`. It holds `read_enable` with `addr` stable until it sees `read_data_valid`, and it samples `read_data` in that same cycle.
- In-window test: `addr[15:k] == BASE_ADDR[15:k]`, where k = `$clog2(NUM_REGS)`. The register index is `addr[k-1:0]`.
- States:
  - IDLE: on `write_enable` or `read_enable` with an in-window `addr`, latch the operation, index and `write_data`. Go to WAIT if `WAIT_CYCLES` > 0, otherwise go to RESP. Out-of-window requests are ignored; the block stays in IDLE.
  - WAIT: a 4-bit counter counts `WAIT_CYCLES` cycles, then goes to RESP. If the enable for the latched operation drops during WAIT, go to IDLE with no commit and no response.
  - RESP: lasts one cycle.
    - Write: `ready` = 1, `o_write_strobe` = 1.
    - Read: `read_data_valid` = 1 and `read_data` = the latched register value.
    - Then go to HOLD.
  - HOLD: lasts one cycle; all requests are ignored. This guards against a request the master has not yet dropped. Then go to IDLE.
- Write commit: the register is updated on the clock edge that enters RESP, so the new value is visible on `o_regs` during RESP. `o_write_index` is updated on the same edge.
- Read value: captured on the edge that enters RESP. A write and read to the same register never overlap, because there is only one outstanding transaction.
- Simultaneous `write_enable` and `read_enable` in IDLE: the write is served and the read is ignored.
- `read_data` is 8'h00 whenever `read_data_valid` = 0.
- `ready` is never asserted for reads, and `read_data_valid` is never asserted for writes.

## Timing
- All outputs are registered. The only combinational path is the in-window decode into the next-state logic.
- The request is first seen high in cycle 0.
  - `ready` or `read_data_valid` is high in cycle 1+`WAIT_CYCLES`, for exactly one cycle.
  - HOLD is cycle 2+`WAIT_CYCLES`.
  - The earliest next accept is cycle 3+`WAIT_CYCLES`.
- Master block write (B command) with `WAIT_CYCLES`=0: a new byte arrives at most every UART byte time, so there is no back-pressure concern.
- Reset values: `ready`, `read_data_valid` and `o_write_strobe` = 0; `read_data` = 0; `o_write_index` = 0; all registers = `RESET_VALUE`; state = IDLE; counter = 0.
- Reset asserted mid-transaction: the block clears immediately and issues no response. The master must be reset alongside it.

## Test plan
- Reset: with `RESET_VALUE`=8'hA5, assert and release `rst_n` → every `o_regs` byte = 8'hA5 and all handshake outputs = 0.
- Write with `BASE_ADDR`=16'h0100, `WAIT_CYCLES`=2, writing 8'h3C to 16'h0105 → `ready` high in cycle 3 only; `o_regs[47:40]` = 8'h3C in cycle 3; `o_write_strobe` pulses in cycle 3 with `o_write_index` = 5.
- Read back 16'h0105 → `read_data_valid` high in cycle 3 with `read_data` = 8'h3C; `read_data` = 0 in every other cycle.
- Out-of-window access: write or read to 16'h0200 held for 40 cycles → no `ready`, no `read_data_valid`, `o_regs` unchanged.
- Abort: `read_enable` dropped in cycle 1 with `WAIT_CYCLES`=4 → no `read_data_valid`, state back in IDLE. A following write to 16'h0100 completes normally.
- Simultaneous enables: `write_enable` and `read_enable` both high to 16'h010F with data 8'h77 → only `ready` is asserted; register 15 = 8'h77. Also assert `rst_n` low during WAIT → outputs clear at once and no response follows.

Source files
------------

// File: rtl/debug_bus_regbank_if.sv
// Debug bus carrying single-byte reads and writes from the UART-driven master to its responders.
// Latency: none, this is wiring only; timing is set by master and responders.
// Backpressure: master holds a write until ready, a read until read_data_valid.
interface debug_bus_if;
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        write_enable;
    logic        read_enable;
    logic        ready;
    logic [7:0]  read_data;
    logic        read_data_valid;

    modport master (
        output addr, write_data, write_enable, read_enable,
        input  ready, read_data, read_data_valid
    );

    modport slave (
        input  addr, write_data, write_enable, read_enable,
        output ready, read_data, read_data_valid
    );
endinterface

// File: rtl/debug_bus_regbank.sv
// Debug-bus responder holding a window of 8-bit static configuration registers.
// Latency: response one cycle after the request, plus WAIT_CYCLES; then one HOLD cycle.
// Backpressure: master holds its request until ready/read_data_valid; one transaction at a time.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   dbus            - debug bus responder side (addr/write_data/enables in; ready/read_data/read_data_valid out)
//   o_regs          - all register contents, register i at bits [8i+7:8i]
//   o_write_strobe  - one-cycle pulse in the cycle a write is committed
//   o_write_index   - index of the most recently committed write
module debug_bus_regbank #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    debug_bus_if.slave                  dbus,
    output logic [NUM_REGS*8-1:0]       o_regs,
    output logic                        o_write_strobe,
    output logic [$clog2(NUM_REGS)-1:0] o_write_index
);

    localparam int IDX_W = $clog2(NUM_REGS);
    // Counter value on the last WAIT cycle; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       op_wr_q, op_wr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [7:0]                 wdat_q, wdat_d;
    logic [NUM_REGS-1:0][7:0]   regs_q;
    logic                       ready_q, rdv_q, strobe_q;
    logic [7:0]                 rdata_q;
    logic [IDX_W-1:0]           widx_q;

    // Operation committed on this edge: comes straight from the bus when
    // there are no wait states, otherwise from the latched copy.
    logic                       resp_go;
    logic                       c_wr;
    logic [IDX_W-1:0]           c_idx;
    logic [7:0]                 c_dat;

    logic                       in_win;
    assign in_win = (dbus.addr[15:IDX_W] == BASE_ADDR[15:IDX_W]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        resp_go = 1'b0;
        c_wr    = op_wr_q;
        c_idx   = idx_q;
        c_dat   = wdat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_win && (dbus.write_enable || dbus.read_enable)) begin
                    // Write wins when both enables are high.
                    op_wr_d = dbus.write_enable;
                    idx_d   = dbus.addr[IDX_W-1:0];
                    wdat_d  = dbus.write_data;
                    c_wr    = dbus.write_enable;
                    c_idx   = dbus.addr[IDX_W-1:0];
                    c_dat   = dbus.write_data;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        resp_go = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Master gave up: abandon silently, nothing committed.
                if (op_wr_q ? !dbus.write_enable : !dbus.read_enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    resp_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_HOLD;
            // One dead cycle so a request not yet dropped is not re-accepted.
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdat_q   <= 8'h00;
            regs_q   <= {NUM_REGS{RESET_VALUE}};
            ready_q  <= 1'b0;
            rdv_q    <= 1'b0;
            rdata_q  <= 8'h00;
            strobe_q <= 1'b0;
            widx_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            idx_q    <= idx_d;
            wdat_q   <= wdat_d;
            ready_q  <= resp_go && c_wr;
            strobe_q <= resp_go && c_wr;
            rdv_q    <= resp_go && !c_wr;
            rdata_q  <= (resp_go && !c_wr) ? regs_q[c_idx] : 8'h00;
            if (resp_go && c_wr) begin
                regs_q[c_idx] <= c_dat;
                widx_q        <= c_idx;
            end
        end
    end

    assign dbus.ready           = ready_q;
    assign dbus.read_data_valid = rdv_q;
    assign dbus.read_data       = rdata_q;
    assign o_regs               = regs_q;
    assign o_write_strobe       = strobe_q;
    assign o_write_index        = widx_q;

endmodule
